// File: rtl/fp32_divider.sv
// IEEE-754 single-precision divider (result = a / b).
// Radix-2 restoring mantissa division, one quotient bit per cycle, with
// valid/ready handshakes on both sides. Denormal inputs and underflowed
// results flush to zero; NaN outputs are {sign, 8'hFF, 23'h400000}.
module fp32_divider #(
  parameter int ROUND_MODE = 0  // 0: nearest-even, 1: truncate
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [4:0]  flags
);

  typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;

  state_t                state_q, state_d;
  logic                  sign_q, sign_d;
  logic signed [9:0]     e_q, e_d;
  logic [25:0]           r_q, r_d;
  logic [23:0]           mb_q, mb_d;
  logic [25:0]           q_q, q_d;
  logic [4:0]            cnt_q, cnt_d;
  logic [31:0]           result_q, result_d;
  logic [4:0]            flags_q, flags_d;

  // Classify operands; returns {is_special, flags, result}.
  function automatic logic [37:0] special_case(input logic [31:0] x,
                                               input logic [31:0] y,
                                               input logic        s);
    logic xz, xi, xn, yz, yi, yn;
    logic [37:0] o;
    xz = (x[30:23] == 8'h00);
    xi = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    xn = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    yz = (y[30:23] == 8'h00);
    yi = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
    yn = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
    o = {1'b1, 5'b00000, s, 8'hFF, 23'h400000};
    if (xn || yn)
      o = {1'b1, 5'b00000, s, 8'hFF, 23'h400000};
    else if ((xz && yz) || (xi && yi))
      o = {1'b1, 5'b10000, s, 8'hFF, 23'h400000};
    else if (xi)
      o = {1'b1, 5'b00000, s, 8'hFF, 23'd0};
    else if (yz)
      o = {1'b1, 5'b01000, s, 8'hFF, 23'd0};
    else if (xz || yi)
      o = {1'b1, 5'b00000, s, 31'd0};
    else
      o = {1'b0, 5'b00000, 32'd0};
    return o;
  endfunction

  // Normalise, round and range-check the raw quotient; returns {flags, result}.
  function automatic logic [36:0] round_pack(input logic              s,
                                             input logic [25:0]       q,
                                             input logic              rem_nz,
                                             input logic signed [9:0] e_in);
    logic [23:0]       mant;
    logic              guard, sticky, up;
    logic [24:0]       sum;
    logic signed [9:0] e;
    logic [4:0]        f;
    logic [31:0]       r;
    e = e_in;
    if (q[25]) begin
      mant   = q[25:2];
      guard  = q[1];
      sticky = q[0] | rem_nz;
    end else begin
      mant   = q[24:1];
      guard  = q[0];
      sticky = rem_nz;
      e      = e - 10'sd1;
    end
    up  = (ROUND_MODE == 0) && guard && (sticky || mant[0]);
    sum = {1'b0, mant} + {24'd0, up};
    if (sum[24]) begin
      mant = 24'h800000;
      e    = e + 10'sd1;
    end else begin
      mant = sum[23:0];
    end
    f = {4'b0000, guard | sticky};
    if (e >= 10'sd255) begin
      f[2] = 1'b1;
      f[0] = 1'b1;
      r = (ROUND_MODE == 0) ? {s, 8'hFF, 23'd0} : {s, 8'hFE, 23'h7FFFFF};
    end else if (e <= 10'sd0) begin
      f[1] = 1'b1;
      f[0] = 1'b1;
      r = {s, 31'd0};
    end else begin
      r = {s, e[7:0], mant[22:0]};
    end
    return {f, r};
  endfunction

  logic [37:0] spec_w;
  logic [36:0] rnd_w;
  logic        qbit;
  logic [25:0] r_sub;

  assign spec_w = special_case(a, b, a[31] ^ b[31]);
  assign rnd_w  = round_pack(sign_q, q_q, (r_q != 26'd0), e_q);

  // Next-state and datapath next values.
  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    e_d      = e_q;
    r_d      = r_q;
    mb_d     = mb_q;
    q_d      = q_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    flags_d  = flags_q;
    qbit     = 1'b0;
    r_sub    = r_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d = a[31] ^ b[31];
          if (spec_w[37]) begin
            state_d  = DONE;
            flags_d  = spec_w[36:32];
            result_d = spec_w[31:0];
          end else begin
            state_d = DIV;
            r_d     = {2'b00, 1'b1, a[22:0]};
            mb_d    = {1'b1, b[22:0]};
            q_d     = 26'd0;
            cnt_d   = 5'd0;
            e_d     = $signed({2'b00, a[30:23]}) - $signed({2'b00, b[30:23]}) + 10'sd127;
          end
        end
      end
      DIV: begin
        if (r_q >= {2'b00, mb_q}) begin
          qbit  = 1'b1;
          r_sub = r_q - {2'b00, mb_q};
        end
        r_d   = {r_sub[24:0], 1'b0};
        q_d   = {q_q[24:0], qbit};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd25) state_d = ROUND;
      end
      ROUND: begin
        state_d  = DONE;
        flags_d  = rnd_w[36:32];
        result_d = rnd_w[31:0];
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    result    = result_q;
    flags     = flags_q;
  end

  // Control and visible-result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= 32'd0;
      flags_q  <= 5'd0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  // Iteration datapath registers; contents are don't-care outside DIV/ROUND.
  always_ff @(posedge clk) begin
    sign_q <= sign_d;
    e_q    <= e_d;
    r_q    <= r_d;
    mb_q   <= mb_d;
    q_q    <= q_d;
    cnt_q  <= cnt_d;
  end

endmodule

// File: tb/tb_fp32_divider.sv
// Directed bench for fp32_divider: one DUT per rounding mode, shared stimulus.
module tb_fp32_divider;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] a, b;
  logic        in_ready0, out_valid0, in_ready1, out_valid1;
  logic [31:0] result0, result1;
  logic [4:0]  flags0, flags1;

  int total = 0;
  int bad   = 0;

  fp32_divider #(.ROUND_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .out_valid(out_valid0), .out_ready(out_ready),
    .result(result0), .flags(flags0)
  );

  fp32_divider #(.ROUND_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .out_valid(out_valid1), .out_ready(out_ready),
    .result(result1), .flags(flags1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until out_valid rises; -1 when the budget runs out.
  task automatic wait_out(output int lat);
    lat = -1;
    for (int i = 0; i <= 100; i++) begin
      if (out_valid0) begin
        lat = i;
        break;
      end
      step();
    end
  endtask

  // Presents one operand pair, returns edges from accept to out_valid.
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv, output int lat);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a = av;
    b = bv;
    step();
    in_valid = 1'b0;
    wait_out(lat);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    total++; if (in_ready0 !== 1'b1) begin bad++; $display("FAIL reset_in_ready got %b want 1", in_ready0); end
    total++; if (out_valid0 !== 1'b0) begin bad++; $display("FAIL reset_out_valid got %b want 0", out_valid0); end
    total++; if (result0 !== 32'd0) begin bad++; $display("FAIL reset_result got %h want 00000000", result0); end
    total++; if (flags0 !== 5'd0) begin bad++; $display("FAIL reset_flags got %b want 00000", flags0); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int lat;
    run_op(32'h40C00000, 32'h40000000, lat);
    total++; if (lat !== 27) begin bad++; $display("FAIL basic_latency got %0d want 27", lat); end
    total++; if (result0 !== 32'h40400000) begin bad++; $display("FAIL basic_result got %h want 40400000", result0); end
    total++; if (flags0 !== 5'b00000) begin bad++; $display("FAIL basic_flags got %b want 00000", flags0); end
    total++; if (result1 !== 32'h40400000) begin bad++; $display("FAIL basic_result_trunc got %h want 40400000", result1); end
    release_out();
    total++; if (out_valid0 !== 1'b0) begin bad++; $display("FAIL basic_drop_valid got %b want 0", out_valid0); end
    total++; if (in_ready0 !== 1'b1) begin bad++; $display("FAIL basic_ready_after got %b want 1", in_ready0); end
  endtask

  task automatic test_third();
    int lat;
    run_op(32'h3F800000, 32'h40400000, lat);
    total++; if (lat !== 27) begin bad++; $display("FAIL third_latency got %0d want 27", lat); end
    total++; if (result0 !== 32'h3EAAAAAB) begin bad++; $display("FAIL third_rne got %h want 3EAAAAAB", result0); end
    total++; if (flags0 !== 5'b00001) begin bad++; $display("FAIL third_rne_flags got %b want 00001", flags0); end
    total++; if (result1 !== 32'h3EAAAAAA) begin bad++; $display("FAIL third_trunc got %h want 3EAAAAAA", result1); end
    total++; if (flags1 !== 5'b00001) begin bad++; $display("FAIL third_trunc_flags got %b want 00001", flags1); end
    release_out();
  endtask

  task automatic test_specials();
    logic [31:0] sa [7];
    logic [31:0] sb [7];
    logic [31:0] sr [7];
    logic [4:0]  sf [7];
    int lat;
    sa = '{32'h3F800000, 32'h00000000, 32'hFF800000, 32'h00000001, 32'h7F800001, 32'h7F800000, 32'h3F800000};
    sb = '{32'h00000000, 32'h00000000, 32'h40000000, 32'h3F800000, 32'h3F800000, 32'h7F800000, 32'h7F800000};
    sr = '{32'h7F800000, 32'h7FC00000, 32'hFF800000, 32'h00000000, 32'h7FC00000, 32'h7FC00000, 32'h00000000};
    sf = '{5'b01000,     5'b10000,     5'b00000,     5'b00000,     5'b00000,     5'b10000,     5'b00000};
    for (int i = 0; i < 7; i++) begin
      run_op(sa[i], sb[i], lat);
      total++; if (lat !== 0) begin bad++; $display("FAIL special%0d_latency got %0d want 0", i, lat); end
      total++; if (result0 !== sr[i]) begin bad++; $display("FAIL special%0d_result got %h want %h", i, result0, sr[i]); end
      total++; if (flags0 !== sf[i]) begin bad++; $display("FAIL special%0d_flags got %b want %b", i, flags0, sf[i]); end
      release_out();
    end
  endtask

  task automatic test_range();
    int lat;
    run_op(32'h7F000000, 32'h3E800000, lat);
    total++; if (result0 !== 32'h7F800000) begin bad++; $display("FAIL overflow_rne got %h want 7F800000", result0); end
    total++; if (flags0 !== 5'b00101) begin bad++; $display("FAIL overflow_flags got %b want 00101", flags0); end
    total++; if (result1 !== 32'h7F7FFFFF) begin bad++; $display("FAIL overflow_trunc got %h want 7F7FFFFF", result1); end
    release_out();
    run_op(32'h00800000, 32'h40000000, lat);
    total++; if (result0 !== 32'h00000000) begin bad++; $display("FAIL underflow_result got %h want 00000000", result0); end
    total++; if (flags0 !== 5'b00011) begin bad++; $display("FAIL underflow_flags got %b want 00011", flags0); end
    release_out();
  endtask

  task automatic test_back_to_back();
    int lat;
    run_op(32'h40C00000, 32'h40000000, lat);
    in_valid = 1'b1;
    a = 32'h3F800000;
    b = 32'h40400000;
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (result0 !== 32'h40400000) begin bad++; $display("FAIL hold%0d_result got %h want 40400000", i, result0); end
      total++; if (flags0 !== 5'b00000) begin bad++; $display("FAIL hold%0d_flags got %b want 00000", i, flags0); end
      total++; if (in_ready0 !== 1'b0) begin bad++; $display("FAIL hold%0d_in_ready got %b want 0", i, in_ready0); end
      total++; if (out_valid0 !== 1'b1) begin bad++; $display("FAIL hold%0d_out_valid got %b want 1", i, out_valid0); end
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total++; if (out_valid0 !== 1'b0) begin bad++; $display("FAIL b2b_idle_valid got %b want 0", out_valid0); end
    total++; if (in_ready0 !== 1'b1) begin bad++; $display("FAIL b2b_idle_ready got %b want 1", in_ready0); end
    step();
    in_valid = 1'b0;
    total++; if (in_ready0 !== 1'b0) begin bad++; $display("FAIL b2b_accept got %b want 0", in_ready0); end
    wait_out(lat);
    total++; if (lat !== 27) begin bad++; $display("FAIL b2b_latency got %0d want 27", lat); end
    total++; if (result0 !== 32'h3EAAAAAB) begin bad++; $display("FAIL b2b_result got %h want 3EAAAAAB", result0); end
    release_out();
  endtask

  task automatic test_reset_mid();
    int lat;
    in_valid = 1'b1;
    a = 32'h40C00000;
    b = 32'h40000000;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) step();
    rst_n = 1'b0;
    step();
    total++; if (out_valid0 !== 1'b0) begin bad++; $display("FAIL midrst_valid got %b want 0", out_valid0); end
    total++; if (in_ready0 !== 1'b1) begin bad++; $display("FAIL midrst_ready got %b want 1", in_ready0); end
    total++; if (result0 !== 32'd0) begin bad++; $display("FAIL midrst_result got %h want 00000000", result0); end
    rst_n = 1'b1;
    run_op(32'h40C00000, 32'h40000000, lat);
    total++; if (lat !== 27) begin bad++; $display("FAIL midrst_latency got %0d want 27", lat); end
    total++; if (result0 !== 32'h40400000) begin bad++; $display("FAIL midrst_result2 got %h want 40400000", result0); end
    release_out();
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a = 32'd0;
    b = 32'd0;
    test_reset();
    test_basic();
    test_third();
    test_specials();
    test_range();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
